csr_issue_stage: RTL

- ID/EX-side issue stage that feeds the CSR register file: decodes SYSTEM-opcode CSR instructions and registers the CSR address, operation type, rs1 operand and zero-extended zimm operand.
- Also registers the write-back destination (rd and enable) and flags illegal encodings.
- Serialises CSR instructions: a new CSR op cannot issue until the previous one has drained through the negedge-updated CSR file. This is enforced by a drain counter and a stall request to the hazard unit.

---
 rtl/csr_issue_stage_pkg.sv | 20 ++
 rtl/csr_issue_stage_csr_decode.sv | 32 +++
 rtl/csr_issue_stage.sv | 91 +++++++++
 3 files changed

// File: rtl/csr_issue_stage_pkg.sv
// Shared constants for the CSR issue stage: CSR type codes, SYSTEM opcode,
// and the default drain length.
package csr_issue_stage_pkg;

  typedef enum logic [2:0] {
    NOTCSR = 3'd0,
    CSRRW  = 3'd1,
    CSRRS  = 3'd2,
    CSRRC  = 3'd3,
    CSRRWI = 3'd5,
    CSRRSI = 3'd6,
    CSRRCI = 3'd7
  } csr_type_e;

  localparam logic [6:0] OPCODE_SYSTEM    = 7'b1110011;
  localparam logic [2:0] FUNCT3_PRIV      = 3'b000;
  localparam logic [2:0] FUNCT3_ILLEGAL   = 3'b100;
  localparam int         DRAIN_CYCLES_DEF = 2;

endpackage

// File: rtl/csr_issue_stage_csr_decode.sv
// Pure combinational decode of a SYSTEM-opcode CSR instruction into type,
// address, rd, zimm and an illegal-encoding flag.
module csr_issue_stage_csr_decode
  import csr_issue_stage_pkg::*;
(
  input  logic        valid,
  input  logic [31:0] inst,
  output logic        is_csr,
  output logic        illegal,
  output csr_type_e   csr_type,
  output logic [11:0] csr_addr,
  output logic [4:0]  rd,
  output logic [4:0]  zimm
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       is_system;

  assign opcode    = inst[6:0];
  assign funct3    = inst[14:12];
  assign is_system = valid & (opcode == OPCODE_SYSTEM);

  // funct3 000 covers ecall/ebreak/mret: not a CSR op, but not illegal here.
  assign is_csr   = is_system & (funct3 != FUNCT3_PRIV) & (funct3 != FUNCT3_ILLEGAL);
  assign illegal  = is_system & (funct3 == FUNCT3_ILLEGAL);
  assign csr_type = is_csr ? csr_type_e'(funct3) : NOTCSR;
  assign csr_addr = inst[31:20];
  assign rd       = inst[11:7];
  assign zimm     = inst[19:15];

endmodule

// File: rtl/csr_issue_stage.sv
// CSR issue stage: registers decoded CSR fields for the CSR file and holds off
// a following CSR op until the previous one has drained through the file.
module csr_issue_stage
  import csr_issue_stage_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int XLEN         = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] rs1_data_i,
  output logic [11:0]     csr_addr_o,
  output logic [2:0]      csr_type_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic [XLEN-1:0] csr_zimm_o,
  output logic [4:0]      csr_rd_o,
  output logic            csr_wb_en_o,
  output logic            illegal_o,
  output logic            csr_busy_o
);

  logic        dec_is_csr;
  logic        dec_illegal;
  csr_type_e   dec_type;
  logic [11:0] dec_addr;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_zimm;

  logic [2:0]  cnt;
  csr_type_e   type_q;
  logic        capture;

  csr_issue_stage_csr_decode u_decode (
    .valid    (valid_i),
    .inst     (inst_i),
    .is_csr   (dec_is_csr),
    .illegal  (dec_illegal),
    .csr_type (dec_type),
    .csr_addr (dec_addr),
    .rd       (dec_rd),
    .zimm     (dec_zimm)
  );

  assign csr_busy_o = dec_is_csr & (cnt != 3'd0);
  assign capture    = en_i & ~flush_i & ~csr_busy_o;
  assign csr_type_o = type_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= 3'd0;
      type_q      <= NOTCSR;
      csr_addr_o  <= '0;
      csr_wdata_o <= '0;
      csr_zimm_o  <= '0;
      csr_rd_o    <= '0;
      csr_wb_en_o <= 1'b0;
      illegal_o   <= 1'b0;
    end else begin
      // The counter keeps draining through flushes and stalls: an older op may
      // still be in flight in the CSR file.
      if (capture && dec_is_csr) begin
        cnt <= 3'(DRAIN_CYCLES);
      end else if (cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end

      if (flush_i || (en_i && csr_busy_o)) begin
        type_q      <= NOTCSR;
        csr_addr_o  <= '0;
        csr_wdata_o <= '0;
        csr_zimm_o  <= '0;
        csr_rd_o    <= '0;
        csr_wb_en_o <= 1'b0;
        illegal_o   <= 1'b0;
      end else if (en_i) begin
        type_q      <= dec_type;
        csr_addr_o  <= dec_addr;
        csr_wdata_o <= rs1_data_i;
        csr_zimm_o  <= {{(XLEN-5){1'b0}}, dec_zimm};
        csr_rd_o    <= dec_rd;
        csr_wb_en_o <= dec_is_csr & (dec_rd != 5'd0);
        illegal_o   <= dec_illegal;
      end
    end
  end

endmodule
